pin_entry: RTL and testbench
============================

# pin_entry

Collects single-cycle button pulses from the debounce stage into a four-digit BCD PIN for the ATM controller. Up/next buttons dial and advance digits. Enter commits the PIN. Clear aborts. An idle timer abandons stale entry. The committed PIN is held with `pin_valid` until the downstream authentication logic acknowledges it.

## Interface
- `TIMEOUT_TICKS`, default 40: consecutive idle `clk` cycles in ENTRY before abort (40 × 250 ms = 10 s); legal range 2..255.
- `clk`  in  1  debounced-button clock, 250 ms period; all logic rises on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_up`  in  1  one-cycle pulse: increment current digit.
- `btn_next`  in  1  one-cycle pulse: advance to next digit.
- `btn_enter`  in  1  one-cycle pulse: commit PIN.
- `btn_clear`  in  1  one-cycle pulse: abort entry.
- `pin_ack`  in  1  downstream has consumed `pin`.
- `pin`  out  16  BCD PIN; first-entered digit in [15:12].
- `pin_valid`  out  1  level: `pin` is committed and stable.
- `cur_pos`  out  2  digit position being edited, 0..3.
- `cur_digit`  out  4  BCD value at `cur_pos`, for the display.
- `entry_active`  out  1  high in ENTRY.
- `timeout`  out  1  one-cycle pulse: entry abandoned by the idle timer.
- `err`  out  1  one-cycle pulse: enter pressed before position 3.

## Operation
- States: IDLE, ENTRY, DONE. The state encoding is in the package.
- All outputs are registered. On reset: state IDLE, `pin`=0, `cur_pos`=0, `cur_digit`=0, and all 1-bit outputs 0.
- Button priority within one cycle: clear > enter > next > up. Exactly one action is taken per cycle.
- **IDLE**
  - `btn_up` or `btn_next`: go to ENTRY, and process the same press as in ENTRY.
  - `btn_enter`, `btn_clear`, `pin_ack`: ignored.
- **ENTRY**
  - up: digit[cur_pos] becomes digit+1, wrapping 9→0.
  - next: `cur_pos`+1 if below 3. At position 3 it is ignored (no wrap).
  - enter at `cur_pos`=3: go to DONE and set `pin_valid`=1.
  - enter at `cur_pos`<3: pulse `err` and stay in ENTRY with digits unchanged.
  - clear: go to IDLE; all digits and `cur_pos` become 0.
  - Timeout: after TIMEOUT_TICKS consecutive cycles with no button pulse, go to IDLE, clear digits and `cur_pos`, and pulse `timeout`.
- **DONE**
  - `pin` is frozen. All buttons are ignored and the idle timer does not run.
  - `pin_ack`: go to IDLE, set `pin_valid`=0, clear `pin`, `cur_pos` and digits.
- Digit registers hold 0..9 only. Values 10..15 are unreachable.
- Idle counter:
  - width `$clog2(TIMEOUT_TICKS+1)`;
  - zeroed on any button pulse, on leaving ENTRY, and on reset;
  - increments each cycle in ENTRY with no pulse.
  - Timeout fires on the edge where the count would reach TIMEOUT_TICKS.

## Timing
- A pulse sampled at edge n is reflected on the outputs after edge n. Latency is 1 cycle, for example `pin_valid` rises one cycle after `btn_enter`.
- `timeout` and `err` stay high for exactly one cycle.
- Entry into ENTRY from IDLE and the first digit update happen on the same edge.
- `pin_ack` is sampled only in DONE. If `pin_ack` is held high across several cycles, only the first cycle matters. Subsequent IDLE cycles ignore it.
- Asserting `rst` in any state, including mid-entry or DONE, forces the reset values immediately. No pulse is emitted.
- A timeout and a button press in the same cycle: the press wins and the counter zeroes.

## Structure
- `pin_entry_pkg` contains:
  - the state enum `pin_state_t` (IDLE, ENTRY, DONE);
  - `NUM_DIGITS`=4;
  - `DIGIT_MAX`=4'd9.
- Sub-module `pin_idle_timer`, parameterised by TIMEOUT_TICKS.
  - Inputs: `clk`, `rst`, `run`, `kick`.
  - Output: `expire` pulse.
- FSM, digit registers and output registers stay in `pin_entry`.

## Test plan
- Dial 1,2,3,4 (up ×1, next, up ×2, next, up ×3, next, up ×4), then enter → next cycle `pin`=16'h1234, `pin_valid`=1. Then `pin_ack` → `pin_valid`=0, `pin`=0, IDLE.
- up ×10 at position 0 → `cur_digit` steps 1..9 then 0. next ×5 → `cur_pos` saturates at 3.
- Enter at `cur_pos`=1 → `err` high for 1 cycle, `entry_active` stays 1, digits unchanged.
- TIMEOUT_TICKS=4: one up, then 4 idle cycles → `timeout` pulse on the 4th, state IDLE, `cur_digit`=0. A press on the 3rd idle cycle prevents the timeout.
- btn_clear together with btn_up in ENTRY → IDLE with all digits 0, no increment. btn_up while in DONE → `pin` unchanged.
- Assert `rst` mid-DONE (`pin`=16'h1234) → all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/pin_entry_pkg.sv
// Shared types and constants for the four-digit BCD PIN entry block.
// Digit increment helper wraps 9 -> 0 so digit registers never leave 0..9.
package pin_entry_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      DONE  = 2'd2
   } pin_state_t;

   localparam int unsigned NUM_DIGITS = 4;
   localparam logic [3:0]  DIGIT_MAX  = 4'd9;

   function automatic logic [3:0] bcd_inc(input logic [3:0] d);
      return (d >= DIGIT_MAX) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/pin_idle_timer.sv
// Idle cycle counter: expires on the cycle the count would reach TIMEOUT_TICKS.
// A kick or a deasserted run zeroes the count; expire itself is combinational.
module pin_idle_timer #(
   parameter int unsigned TIMEOUT_TICKS = 40
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic kick,
   output logic expire
);

   localparam int unsigned   W    = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [W-1:0]  LAST = W'(TIMEOUT_TICKS - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      expire = run && !kick && (cnt_q == LAST);
      if (!run || kick || expire)
         cnt_d = '0;
      else
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pin_entry.sv
// Collects debounced button pulses into a four-digit BCD PIN and holds the
// committed PIN with pin_valid until the downstream logic acknowledges it.
module pin_entry
   import pin_entry_pkg::*;
#(
   parameter int unsigned TIMEOUT_TICKS = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_next,
   input  logic        btn_enter,
   input  logic        btn_clear,
   input  logic        pin_ack,
   output logic [15:0] pin,
   output logic        pin_valid,
   output logic [1:0]  cur_pos,
   output logic [3:0]  cur_digit,
   output logic        entry_active,
   output logic        timeout,
   output logic        err
);

   pin_state_t                   state_q, state_d;
   logic [NUM_DIGITS-1:0][3:0]   digits_q, digits_d;
   logic [1:0]                   pos_q, pos_d;
   logic [15:0]                  pin_q, pin_d;
   logic                         valid_q, valid_d;
   logic [3:0]                   cur_digit_q, cur_digit_d;
   logic                         active_q, active_d;
   logic                         timeout_q, timeout_d;
   logic                         err_q, err_d;
   logic                         any_btn;
   logic                         expire;

   assign any_btn = btn_up | btn_next | btn_enter | btn_clear;

   pin_idle_timer #(
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
   ) u_idle_timer (
      .clk    (clk),
      .rst    (rst),
      .run    (state_q == ENTRY),
      .kick   (any_btn),
      .expire (expire)
   );

   always_comb begin
      state_d   = state_q;
      digits_d  = digits_q;
      pos_d     = pos_q;
      pin_d     = pin_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            // enter/clear are treated as absent here, so next > up still applies
            if (btn_next) begin
               state_d = ENTRY;
               pos_d   = pos_q + 2'd1;
            end else if (btn_up) begin
               state_d          = ENTRY;
               digits_d[pos_q]  = bcd_inc(digits_q[pos_q]);
            end
         end
         ENTRY: begin
            if (btn_clear) begin
               state_d  = IDLE;
               digits_d = '0;
               pos_d    = '0;
            end else if (btn_enter) begin
               if (pos_q == 2'd3) begin
                  state_d = DONE;
                  valid_d = 1'b1;
                  pin_d   = {digits_q[0], digits_q[1], digits_q[2], digits_q[3]};
               end else begin
                  err_d = 1'b1;
               end
            end else if (btn_next) begin
               if (pos_q != 2'd3)
                  pos_d = pos_q + 2'd1;
            end else if (btn_up) begin
               digits_d[pos_q] = bcd_inc(digits_q[pos_q]);
            end else if (expire) begin
               state_d   = IDLE;
               digits_d  = '0;
               pos_d     = '0;
               timeout_d = 1'b1;
            end
         end
         DONE: begin
            if (pin_ack) begin
               state_d  = IDLE;
               valid_d  = 1'b0;
               pin_d    = '0;
               digits_d = '0;
               pos_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      cur_digit_d = digits_d[pos_d];
      active_d    = (state_d == ENTRY);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         digits_q    <= '0;
         pos_q       <= '0;
         pin_q       <= '0;
         valid_q     <= 1'b0;
         cur_digit_q <= '0;
         active_q    <= 1'b0;
         timeout_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         digits_q    <= digits_d;
         pos_q       <= pos_d;
         pin_q       <= pin_d;
         valid_q     <= valid_d;
         cur_digit_q <= cur_digit_d;
         active_q    <= active_d;
         timeout_q   <= timeout_d;
         err_q       <= err_d;
      end
   end

   assign pin          = pin_q;
   assign pin_valid    = valid_q;
   assign cur_pos      = pos_q;
   assign cur_digit    = cur_digit_q;
   assign entry_active = active_q;
   assign timeout      = timeout_q;
   assign err          = err_q;

endmodule

// File: tb/tb_pin_entry.sv
// Directed bench for pin_entry with a short idle timeout (4 ticks).
module tb_pin_entry;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_up, btn_next, btn_enter, btn_clear, pin_ack;
   logic [15:0] pin;
   logic        pin_valid;
   logic [1:0]  cur_pos;
   logic [3:0]  cur_digit;
   logic        entry_active, timeout, err;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   pin_entry #(
      .TIMEOUT_TICKS (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_up       (btn_up),
      .btn_next     (btn_next),
      .btn_enter    (btn_enter),
      .btn_clear    (btn_clear),
      .pin_ack      (pin_ack),
      .pin          (pin),
      .pin_valid    (pin_valid),
      .cur_pos      (cur_pos),
      .cur_digit    (cur_digit),
      .entry_active (entry_active),
      .timeout      (timeout),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // one clock cycle with the given buttons; outputs settle #1 after the edge
   task automatic step(input logic u, input logic n, input logic e, input logic c, input logic a);
      @(negedge clk);
      btn_up = u; btn_next = n; btn_enter = e; btn_clear = c; pin_ack = a;
      @(posedge clk);
      #1;
      btn_up = 0; btn_next = 0; btn_enter = 0; btn_clear = 0; pin_ack = 0;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0);
   endtask

   task automatic up_n(input int unsigned k);
      for (int unsigned i = 0; i < k; i++) step(1, 0, 0, 0, 0);
   endtask

   task automatic dial_1234();
      up_n(1); step(0, 1, 0, 0, 0);
      up_n(2); step(0, 1, 0, 0, 0);
      up_n(3); step(0, 1, 0, 0, 0);
      up_n(4);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pin"},   pin, 16'h0000);
      chk({tag, "_valid"}, {15'd0, pin_valid}, 16'd0);
      chk({tag, "_pos"},   {14'd0, cur_pos}, 16'd0);
      chk({tag, "_digit"}, {12'd0, cur_digit}, 16'd0);
      chk({tag, "_active"},{15'd0, entry_active}, 16'd0);
      chk({tag, "_tmo"},   {15'd0, timeout}, 16'd0);
      chk({tag, "_err"},   {15'd0, err}, 16'd0);
   endtask

   initial begin
      rst = 1'b1;
      btn_up = 0; btn_next = 0; btn_enter = 0; btn_clear = 0; pin_ack = 0;
      #3;
      chk_all_zero("reset");
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // enter/clear in IDLE are ignored
      step(0, 0, 1, 0, 0);
      chk("idle_enter_active", {15'd0, entry_active}, 16'd0);
      chk("idle_enter_err",    {15'd0, err}, 16'd0);
      step(0, 0, 0, 1, 0);
      chk("idle_clear_active", {15'd0, entry_active}, 16'd0);

      // dial 1,2,3,4 and commit
      up_n(1);
      chk("first_up_active", {15'd0, entry_active}, 16'd1);
      chk("first_up_digit",  {12'd0, cur_digit}, 16'd1);
      step(0, 1, 0, 0, 0);
      chk("next_pos1",   {14'd0, cur_pos}, 16'd1);
      chk("next_digit0", {12'd0, cur_digit}, 16'd0);
      up_n(2); step(0, 1, 0, 0, 0);
      up_n(3); step(0, 1, 0, 0, 0);
      up_n(4);
      chk("dial_pos3",   {14'd0, cur_pos}, 16'd3);
      chk("dial_digit4", {12'd0, cur_digit}, 16'd4);
      chk("dial_pin_uncommitted", {15'd0, pin_valid}, 16'd0);
      step(0, 0, 1, 0, 0);
      chk("commit_pin",    pin, 16'h1234);
      chk("commit_valid",  {15'd0, pin_valid}, 16'd1);
      chk("commit_active", {15'd0, entry_active}, 16'd0);
      step(1, 0, 0, 0, 0);
      chk("done_up_pin", pin, 16'h1234);
      for (int i = 0; i < 6; i++) idle();
      chk("done_idle_valid", {15'd0, pin_valid}, 16'd1);
      chk("done_idle_tmo",   {15'd0, timeout}, 16'd0);
      step(0, 0, 0, 0, 1);
      chk("ack_valid",  {15'd0, pin_valid}, 16'd0);
      chk("ack_pin",    pin, 16'h0000);
      chk("ack_active", {15'd0, entry_active}, 16'd0);
      step(0, 0, 0, 0, 1);
      chk("ack_held_active", {15'd0, entry_active}, 16'd0);

      // digit wrap and position saturation
      for (int unsigned k = 1; k <= 10; k++) begin
         step(1, 0, 0, 0, 0);
         chk($sformatf("wrap_%0d", k), {12'd0, cur_digit}, 16'(k % 10));
      end
      for (int unsigned k = 1; k <= 5; k++) begin
         step(0, 1, 0, 0, 0);
         chk($sformatf("sat_%0d", k), {14'd0, cur_pos}, 16'((k > 3) ? 3 : k));
      end
      step(0, 0, 0, 1, 0);
      chk("clear_active", {15'd0, entry_active}, 16'd0);
      chk("clear_pos",    {14'd0, cur_pos}, 16'd0);

      // next from IDLE enters ENTRY at position 1
      step(0, 1, 0, 0, 0);
      chk("idle_next_active", {15'd0, entry_active}, 16'd1);
      chk("idle_next_pos",    {14'd0, cur_pos}, 16'd1);
      up_n(2);
      step(0, 0, 1, 0, 0);
      chk("early_enter_err",    {15'd0, err}, 16'd1);
      chk("early_enter_active", {15'd0, entry_active}, 16'd1);
      chk("early_enter_digit",  {12'd0, cur_digit}, 16'd2);
      chk("early_enter_pos",    {14'd0, cur_pos}, 16'd1);
      idle();
      chk("err_one_cycle", {15'd0, err}, 16'd0);
      step(0, 1, 0, 0, 0);
      step(1, 0, 0, 1, 0);
      chk("clear_up_active", {15'd0, entry_active}, 16'd0);
      chk("clear_up_digit",  {12'd0, cur_digit}, 16'd0);
      chk("clear_up_pos",    {14'd0, cur_pos}, 16'd0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("after_clear_digit1", {12'd0, cur_digit}, 16'd0);
      step(0, 0, 0, 1, 0);

      // idle timeout after 4 quiet cycles
      up_n(1);
      for (int i = 1; i <= 3; i++) begin
         idle();
         chk($sformatf("pre_tmo_%0d", i), {15'd0, timeout}, 16'd0);
      end
      chk("pre_tmo_active", {15'd0, entry_active}, 16'd1);
      idle();
      chk("tmo_pulse",  {15'd0, timeout}, 16'd1);
      chk("tmo_active", {15'd0, entry_active}, 16'd0);
      chk("tmo_digit",  {12'd0, cur_digit}, 16'd0);
      idle();
      chk("tmo_one_cycle", {15'd0, timeout}, 16'd0);

      // a press on the third idle cycle restarts the count
      up_n(1);
      idle(); idle();
      step(1, 0, 0, 0, 0);
      chk("kick_digit", {12'd0, cur_digit}, 16'd2);
      idle(); idle(); idle();
      chk("kick_no_tmo",  {15'd0, timeout}, 16'd0);
      chk("kick_active",  {15'd0, entry_active}, 16'd1);
      idle();
      chk("kick_late_tmo", {15'd0, timeout}, 16'd1);

      // asynchronous reset while in DONE
      dial_1234();
      step(0, 0, 1, 0, 0);
      chk("pre_rst_pin", pin, 16'h1234);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      idle();
      chk("post_rst_valid", {15'd0, pin_valid}, 16'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

endmodule
